branch_resolution_unit: RTL and testbench

- Consumer and checker side of the fetch-stage branch predictor. Sits between IF and ID.
- Records every prediction issued in IF (pc, taken bit, target) in a small in-order queue.
- When ID resolves a branch, pops the queue head and compares prediction against outcome. Produces the misprediction flag, redirect PC, pipeline flush, and the predictor training/update command.

---
 rtl/branch_resolution_unit.sv | 173 +++++++++++++++++
 tb/tb_branch_resolution_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: queues IF predictions, checks them against ID
// outcomes, and issues redirect, flush and predictor-training commands.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                pipeline advance (0 = hold)
//   if_*              prediction issued by IF (push)
//   id_*              outcome resolved in ID (pop and compare)
//   queue_full/empty  combinational queue status
//   misprediction, redirect_valid, redirect_pc   registered redirect
//   flush             high while recovering from a misprediction
//   btb_update*       registered training command per resolved branch
module branch_resolution_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int QUEUE_DEPTH  = 4,
  parameter int PTR_WIDTH    = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  if_valid,
  input  logic [DATA_WIDTH-1:0] if_pc,
  input  logic                  if_pred_taken,
  input  logic [DATA_WIDTH-1:0] if_pred_target,
  input  logic                  id_valid,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic                  id_taken,
  input  logic [DATA_WIDTH-1:0] id_target,
  output logic                  queue_full,
  output logic                  queue_empty,
  output logic                  misprediction,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  flush,
  output logic                  btb_update,
  output logic [DATA_WIDTH-1:0] btb_update_pc,
  output logic [DATA_WIDTH-1:0] btb_update_target,
  output logic                  btb_update_mispredict
);

  typedef enum logic {
    NORMAL,
    FLUSH
  } state_t;

  localparam int CW = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [PTR_WIDTH:0] DEPTH =
    (PTR_WIDTH+1)'(QUEUE_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(FLUSH_CYCLES - 1);

  logic [DATA_WIDTH-1:0]  q_pc     [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]  q_target [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] q_taken;

  logic [PTR_WIDTH-1:0] head;
  logic [PTR_WIDTH-1:0] tail;
  logic [PTR_WIDTH:0]   count;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  logic active;
  logic hit_wrong;
  logic mis;
  logic do_pop;
  logic do_push;

  assign queue_full  = (count == DEPTH);
  assign queue_empty = (count == '0);

  assign active = en && (state == NORMAL);

  assign hit_wrong = (q_pc[head] != id_pc)
                  || (q_taken[head] != id_taken)
                  || (id_taken && (q_target[head] != id_target));

  // An empty queue means IF fell through: implicit not-taken.
  assign mis = active && id_valid
            && (queue_empty ? id_taken : hit_wrong);

  assign do_pop  = active && id_valid && !queue_empty;
  // Full is only a problem if nothing leaves this cycle.
  assign do_push = active && if_valid && !mis
                && (!queue_full || do_pop);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (en) begin
      unique case (state)
        NORMAL: begin
          if (mis) begin
            state_nx = FLUSH;
            cnt_nx   = '0;
          end
        end
        FLUSH: begin
          if (cnt == LAST) begin
            state_nx = NORMAL;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NORMAL;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      q_pc[tail]     <= if_pc;
      q_taken[tail]  <= if_pred_taken;
      q_target[tail] <= if_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || mis) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_WIDTH'(1);
      if (do_pop)  head <= head + PTR_WIDTH'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_WIDTH+1)'(1);
        2'b01:   count <= count - (PTR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misprediction         <= 1'b0;
      redirect_valid        <= 1'b0;
      redirect_pc           <= '0;
      flush                 <= 1'b0;
      btb_update            <= 1'b0;
      btb_update_pc         <= '0;
      btb_update_target     <= '0;
      btb_update_mispredict <= 1'b0;
    end else begin
      misprediction  <= mis;
      redirect_valid <= mis;
      btb_update     <= active && id_valid;
      flush          <= (state_nx == FLUSH);
      if (mis) begin
        redirect_pc <= id_taken ? id_target
                                : id_pc + DATA_WIDTH'(4);
      end
      if (active && id_valid) begin
        btb_update_pc         <= id_pc;
        btb_update_target     <= id_target;
        btb_update_mispredict <= mis;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Bench for branch_resolution_unit: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_branch_resolution_unit;

  localparam int DW  = 32;
  localparam int QD  = 4;
  localparam int FC  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          if_valid = 1'b0;
  logic [DW-1:0] if_pc = '0;
  logic          if_pred_taken = 1'b0;
  logic [DW-1:0] if_pred_target = '0;
  logic          id_valid = 1'b0;
  logic [DW-1:0] id_pc = '0;
  logic          id_taken = 1'b0;
  logic [DW-1:0] id_target = '0;
  logic          queue_full;
  logic          queue_empty;
  logic          misprediction;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic          flush;
  logic          btb_update;
  logic [DW-1:0] btb_update_pc;
  logic [DW-1:0] btb_update_target;
  logic          btb_update_mispredict;

  int n_total = 0;
  int n_pass  = 0;

  branch_resolution_unit #(
    .DATA_WIDTH(DW), .QUEUE_DEPTH(QD),
    .PTR_WIDTH(2), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .if_valid(if_valid), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_taken(id_taken), .id_target(id_target),
    .queue_full(queue_full), .queue_empty(queue_empty),
    .misprediction(misprediction),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush),
    .btb_update(btb_update),
    .btb_update_pc(btb_update_pc),
    .btb_update_target(btb_update_target),
    .btb_update_mispredict(btb_update_mispredict)
  );

  always #5 clk = ~clk;

  // Reference model: an in-order list of predictions and a count of
  // remaining flush cycles.
  typedef struct {
    logic [DW-1:0] pc;
    logic          taken;
    logic [DW-1:0] target;
  } ent_t;

  ent_t          mq[$];
  int            m_left = 0;
  logic          m_wrong;
  logic          e_mis = 0, e_rv = 0, e_flush = 0, e_btb = 0, e_bmis = 0;
  logic [DW-1:0] e_rpc = '0, e_bpc = '0, e_btgt = '0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_left = 0;
      e_mis = 0; e_rv = 0; e_flush = 0; e_btb = 0; e_bmis = 0;
      e_rpc = '0; e_bpc = '0; e_btgt = '0;
    end else begin
      e_mis = 0; e_rv = 0; e_btb = 0;
      if (en) begin
        if (m_left > 0) begin
          m_left--;
          e_flush = (m_left > 0);
        end else begin
          m_wrong = 0;
          if (id_valid) begin
            if (mq.size() == 0) m_wrong = id_taken;
            else m_wrong = (mq[0].pc != id_pc)
                        || (mq[0].taken != id_taken)
                        || (id_taken && mq[0].target != id_target);
            e_btb = 1; e_bpc = id_pc; e_btgt = id_target;
            e_bmis = m_wrong;
          end
          if (m_wrong) begin
            e_mis = 1; e_rv = 1;
            e_rpc = id_taken ? id_target : id_pc + 32'd4;
            mq.delete();
            m_left = FC;
            e_flush = 1;
          end else begin
            if (id_valid && mq.size() > 0) void'(mq.pop_front());
            if (if_valid && mq.size() < QD)
              mq.push_back('{if_pc, if_pred_taken, if_pred_target});
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1; if_valid = 0; id_valid = 0; rst = 0;
  endtask

  task automatic push(input logic [DW-1:0] p, input logic t,
                      input logic [DW-1:0] g);
    if_valid = 1; if_pc = p; if_pred_taken = t; if_pred_target = g;
  endtask

  task automatic resolve(input logic [DW-1:0] p, input logic t,
                         input logic [DW-1:0] g);
    id_valid = 1; id_pc = p; id_taken = t; id_target = g;
  endtask

  task automatic test_reset();
    rst = 1; cyc(); cyc();
    idle();
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_total++;
      if (queue_empty !== 1'b1 || queue_full !== 1'b0 || flush !== 1'b0
          || misprediction !== 1'b0 || btb_update !== 1'b0
          || redirect_pc !== '0 || btb_update_pc !== '0)
        $display("FAIL reset_idle cyc%0d got e%b f%b fl%b m%b u%b want e1 f0 fl0 m0 u0",
                 i, queue_empty, queue_full, flush, misprediction, btb_update);
      else n_pass++;
    end
  endtask

  task automatic test_correct();
    push(32'h100, 1, 32'h200); cyc(); idle();
    n_total++;
    if (queue_empty !== 1'b0) $display("FAIL push_nonempty got %b want 0", queue_empty);
    else n_pass++;
    resolve(32'h100, 1, 32'h200); cyc(); idle();
    n_total++;
    if ({btb_update, btb_update_mispredict, misprediction, queue_empty} !== 4'b1001)
      $display("FAIL correct_pred got u%b um%b m%b e%b want 1 0 0 1",
               btb_update, btb_update_mispredict, misprediction, queue_empty);
    else n_pass++;
    n_total++;
    if (btb_update_pc !== 32'h100 || btb_update_target !== 32'h200)
      $display("FAIL correct_train got %h/%h want 100/200", btb_update_pc, btb_update_target);
    else n_pass++;
    cyc();
    n_total++;
    if (btb_update !== 1'b0) $display("FAIL update_pulse got %b want 0", btb_update);
    else n_pass++;
  endtask

  task automatic test_dir_mispredict();
    push(32'h100, 1, 32'h200); cyc(); idle();
    resolve(32'h100, 0, 32'h200); cyc(); idle();
    n_total++;
    if ({misprediction, redirect_valid, btb_update_mispredict, flush} !== 4'b1111)
      $display("FAIL dir_mis got m%b rv%b um%b fl%b want 1111",
               misprediction, redirect_valid, btb_update_mispredict, flush);
    else n_pass++;
    n_total++;
    if (redirect_pc !== 32'h104) $display("FAIL dir_redirect got %h want 104", redirect_pc);
    else n_pass++;
    push(32'h180, 1, 32'h280);
    resolve(32'h180, 1, 32'h280);
    cyc();
    n_total++;
    if ({flush, misprediction, btb_update, queue_empty} !== 4'b1001)
      $display("FAIL flush_c2 got fl%b m%b u%b e%b want 1 0 0 1",
               flush, misprediction, btb_update, queue_empty);
    else n_pass++;
    cyc(); idle();
    n_total++;
    if ({flush, btb_update, queue_empty} !== 3'b001)
      $display("FAIL flush_end got fl%b u%b e%b want 0 0 1", flush, btb_update, queue_empty);
    else n_pass++;
  endtask

  task automatic test_target_mispredict();
    push(32'h40, 1, 32'h80); cyc(); idle();
    resolve(32'h40, 1, 32'h90); cyc(); idle();
    n_total++;
    if (misprediction !== 1'b1 || redirect_pc !== 32'h90)
      $display("FAIL target_mis got m%b pc %h want 1 90", misprediction, redirect_pc);
    else n_pass++;
    cyc(); cyc();
    n_total++;
    if (flush !== 1'b0) $display("FAIL target_flush_end got %b want 0", flush);
    else n_pass++;
  endtask

  task automatic test_full_wrap();
    logic [DW-1:0] dpc [4];
    logic          dtk [4];
    logic [DW-1:0] dtg [4];
    dpc = '{32'h510, 32'h520, 32'h530, 32'h580};
    dtk = '{1'b1, 1'b0, 1'b1, 1'b1};
    dtg = '{32'h620, 32'h640, 32'h660, 32'h700};
    for (int i = 0; i < 4; i++) begin
      push(32'h500 + 32'(i) * 32'h10, i[0], 32'h600 + 32'(i) * 32'h20);
      cyc();
    end
    idle();
    n_total++;
    if (queue_full !== 1'b1) $display("FAIL full_after4 got %b want 1", queue_full);
    else n_pass++;
    push(32'h5f0, 1, 32'h6f0); cyc(); idle();
    n_total++;
    if (queue_full !== 1'b1) $display("FAIL full_drop got %b want 1", queue_full);
    else n_pass++;
    push(32'h580, 1, 32'h700);
    resolve(32'h500, 0, 32'h600);
    cyc(); idle();
    n_total++;
    if (queue_full !== 1'b1 || misprediction !== 1'b0)
      $display("FAIL push_pop_full got f%b m%b want 1 0", queue_full, misprediction);
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) resolve(dpc[k], dtk[k], dtg[k]);
      else resolve(32'h900, 0, 32'h0);
      cyc(); idle();
      n_total++;
      if (misprediction !== 1'b0 || btb_update !== 1'b1)
        $display("FAIL drain%0d got m%b u%b want 0 1", k, misprediction, btb_update);
      else n_pass++;
    end
    n_total++;
    if (queue_empty !== 1'b1) $display("FAIL drain_empty got %b want 1", queue_empty);
    else n_pass++;
  endtask

  task automatic test_empty_reset();
    resolve(32'h300, 1, 32'h400); cyc(); idle();
    n_total++;
    if (misprediction !== 1'b1 || redirect_pc !== 32'h400 || flush !== 1'b1)
      $display("FAIL empty_mis got m%b pc %h fl%b want 1 400 1",
               misprediction, redirect_pc, flush);
    else n_pass++;
    rst = 1; cyc(); rst = 0;
    n_total++;
    if (flush !== 1'b0 || queue_empty !== 1'b1 || misprediction !== 1'b0)
      $display("FAIL rst_in_flush got fl%b e%b m%b want 0 1 0",
               flush, queue_empty, misprediction);
    else n_pass++;
  endtask

  task automatic test_stall();
    push(32'h700, 1, 32'h710); cyc(); idle();
    en = 0; resolve(32'h700, 1, 32'h710); push(32'h7a0, 0, 32'h0);
    cyc(); cyc();
    n_total++;
    if (btb_update !== 1'b0 || queue_empty !== 1'b0 || btb_update_pc !== 32'h0)
      $display("FAIL stall_hold got u%b e%b pc %h want 0 0 0",
               btb_update, queue_empty, btb_update_pc);
    else n_pass++;
    en = 1; if_valid = 0; cyc(); idle();
    n_total++;
    if (btb_update !== 1'b1 || misprediction !== 1'b0
        || queue_empty !== 1'b1 || btb_update_pc !== 32'h700)
      $display("FAIL stall_release got u%b m%b e%b pc %h want 1 0 1 700",
               btb_update, misprediction, queue_empty, btb_update_pc);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [6:0] got, want;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      en = ($urandom_range(0, 7) != 0);
      if_valid = $urandom_range(0, 1);
      if_pc = 32'($urandom_range(0, 31)) << 2;
      if_pred_taken = $urandom_range(0, 1);
      if_pred_target = 32'($urandom_range(0, 31)) << 2;
      id_valid = $urandom_range(0, 1);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        id_pc = mq[0].pc; id_taken = mq[0].taken;
        id_target = mq[0].target;
        if ($urandom_range(0, 7) == 0) id_target = id_target ^ 32'h4;
      end else begin
        id_pc = 32'($urandom_range(0, 31)) << 2;
        id_taken = ($urandom_range(0, 2) == 0);
        id_target = 32'($urandom_range(0, 31)) << 2;
      end
      cyc();
      got = {misprediction, redirect_valid, flush, btb_update,
             btb_update_mispredict, queue_empty, queue_full};
      want = {e_mis, e_rv, e_flush, e_btb, e_bmis,
              mq.size() == 0, mq.size() == QD};
      n_total++;
      if (got !== want)
        $display("FAIL rand%0d_ctl got %b want %b", i, got, want);
      else n_pass++;
      n_total++;
      if (redirect_pc !== e_rpc || btb_update_pc !== e_bpc
          || btb_update_target !== e_btgt)
        $display("FAIL rand%0d_data got %h %h %h want %h %h %h", i,
                 redirect_pc, btb_update_pc, btb_update_target,
                 e_rpc, e_bpc, e_btgt);
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_correct();
    test_dir_mispredict();
    test_target_mispredict();
    test_full_wrap();
    test_empty_reset();
    test_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
